// File: rtl/rbm_stochastic_unit_pkg.sv
// Shared constants and combinational helpers for the RBM stochastic unit:
// Q5.6 saturating adder, piecewise-linear sigmoid and LFSR step function.
package rbm_stochastic_unit_pkg;

  localparam int BITLENGTH         = 12;
  localparam int SIGMOID_BITLENGTH = 8;
  localparam int FRAC_BITS         = 6;

  // Saturation limits are symmetric; -2048 is never produced.
  localparam logic [11:0] INF     = 12'h7FF;
  localparam logic [11:0] NEG_INF = 12'h801;

  // Sigmoid breakpoints on |x| (raw Q5.6 units).
  localparam logic [11:0] SIG_BP0 = 12'd64;
  localparam logic [11:0] SIG_BP1 = 12'd152;
  localparam logic [11:0] SIG_BP2 = 12'd320;

  // Taps for x^8+x^6+x^5+x^4+1 on q[7], q[5], q[4], q[3].
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Saturating 12-bit signed add; an exact -2048 also clamps to -Inf.
  function automatic logic [11:0] ap_adder(input logic [11:0] a, input logic [11:0] b);
    logic signed [12:0] sum_s;
    logic [11:0]        res_s;
    sum_s = $signed({a[11], a}) + $signed({b[11], b});
    if (sum_s > 13'sd2047) begin
      res_s = INF;
    end else if (sum_s < -13'sd2047) begin
      res_s = NEG_INF;
    end else begin
      res_s = sum_s[11:0];
    end
    return res_s;
  endfunction

  // Piecewise-linear sigmoid; output is a probability in units of 1/256.
  function automatic logic [7:0] sigmoid(input logic [11:0] x);
    logic [11:0] mag_s;
    logic [8:0]  p_s;
    logic [8:0]  neg_s;
    logic [7:0]  res_s;
    // Unsigned magnitude: 12'h800 maps to 2048, which is still representable.
    mag_s = x[11] ? (12'd0 - x) : x;
    if (mag_s < SIG_BP0) begin
      p_s = 9'd128 + {3'b000, mag_s[5:0]};
    end else if (mag_s < SIG_BP1) begin
      p_s = 9'd160 + {2'b00, mag_s[7:1]};
    end else if (mag_s < SIG_BP2) begin
      p_s = 9'd216 + {3'b000, mag_s[8:3]};
    end else begin
      p_s = 9'd256;
    end
    // Negative side mirrors around 128; positive side clips 256 to 255.
    neg_s = 9'd256 - p_s;
    if (x[11]) begin
      res_s = neg_s[7:0];
    end else if (p_s[8]) begin
      res_s = 8'hFF;
    end else begin
      res_s = p_s[7:0];
    end
    return res_s;
  endfunction

  // One Fibonacci LFSR step: shift left, feedback into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rbm_stochastic_unit_if.sv
// Datapath bus of the RBM stochastic unit: adder, sigmoid, seed and sample.
interface rbm_stochastic_unit_if;
  import rbm_stochastic_unit_pkg::*;

  logic [7:0]  SeedData;
  logic [11:0] AddA;
  logic [11:0] AddB;
  logic [11:0] AddSum;
  logic [11:0] SigIn;
  logic [7:0]  SigOut;
  logic [7:0]  RandomData;
  logic        Sample;

  // Layer controller side.
  modport master (
    output SeedData, AddA, AddB, SigIn,
    input  AddSum, SigOut, RandomData, Sample
  );

  // Stochastic unit side.
  modport slave (
    input  SeedData, AddA, AddB, SigIn,
    output AddSum, SigOut, RandomData, Sample
  );
endinterface

// File: rtl/rbm_stochastic_unit_lfsr.sv
// 8-bit Fibonacci LFSR random source; zero seeds are promoted to 8'h01 so
// the register can never lock up in the all-zero state.
module rbm_stochastic_unit_lfsr
  import rbm_stochastic_unit_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] random_data
);

  logic [7:0] state_r;
  logic [7:0] seed_s;

  // Substitute a legal nonzero seed for 8'h00.
  always_comb begin
    seed_s = seed;
    if (seed == 8'h00) begin
      seed_s = 8'h01;
    end else begin
      seed_s = seed;
    end
  end

  // Load the seed while reset is high, otherwise advance one step per clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= seed_s;
    end else begin
      state_r <= lfsr_next(state_r);
    end
  end

  assign random_data = state_r;

endmodule

// File: rtl/rbm_stochastic_unit.sv
// RBM stochastic unit: saturating adder, sigmoid, LFSR and the Bernoulli
// sample bit (sigmoid probability strictly greater than the random word).
module rbm_stochastic_unit
  import rbm_stochastic_unit_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  rbm_stochastic_unit_if.slave bus
);

  logic [11:0] add_sum_s;
  logic [7:0]  sig_out_s;
  logic [7:0]  random_s;
  logic        sample_s;

  rbm_stochastic_unit_lfsr u_random_generator (
    .clock       (clock),
    .reset       (reset),
    .seed        (bus.SeedData),
    .random_data (random_s)
  );

  // Pre-activation accumulation step and the activation probability.
  always_comb begin
    add_sum_s = ap_adder(bus.AddA, bus.AddB);
    sig_out_s = sigmoid(bus.SigIn);
  end

  // Bernoulli draw: unit fires when probability exceeds the random word.
  always_comb begin
    sample_s = 1'b0;
    if (sig_out_s > random_s) begin
      sample_s = 1'b1;
    end else begin
      sample_s = 1'b0;
    end
  end

  assign bus.AddSum     = add_sum_s;
  assign bus.SigOut     = sig_out_s;
  assign bus.RandomData = random_s;
  assign bus.Sample     = sample_s;

endmodule

// File: tb/tb_rbm_stochastic_unit.sv
// Directed self-checking bench for rbm_stochastic_unit.
module tb_rbm_stochastic_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  rbm_stochastic_unit_if bus ();

  rbm_stochastic_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Raise reset between edges with the given seed (async load).
  task automatic apply_reset(input logic [7:0] seed);
    @(negedge clock);
    bus.SeedData = seed;
    reset = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(8'h5A);
    total_cnt++;
    if (bus.RandomData !== 8'h5A) $display("FAIL reset_load: got %h expected %h", bus.RandomData, 8'h5A);
    else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++;
    if (bus.RandomData !== 8'h5A) $display("FAIL reset_hold: got %h expected %h", bus.RandomData, 8'h5A);
    else pass_cnt++;
    release_reset();
  endtask

  task automatic test_adder();
    logic [11:0] a_v [4] = '{12'h005, 12'h7F0, 12'h800, 12'h400};
    logic [11:0] b_v [4] = '{12'hFFD, 12'h020, 12'hFFF, 12'h3FF};
    logic [11:0] e_v [4] = '{12'h002, 12'h7FF, 12'h801, 12'h7FF};
    for (int i = 0; i < 4; i++) begin
      bus.AddA = a_v[i];
      bus.AddB = b_v[i];
      #1;
      total_cnt++;
      if (bus.AddSum !== e_v[i])
        $display("FAIL adder_%0d: %h+%h got %h expected %h", i, a_v[i], b_v[i], bus.AddSum, e_v[i]);
      else pass_cnt++;
    end
    // Exact -2048 clamps to -Inf.
    bus.AddA = 12'h800;
    bus.AddB = 12'h000;
    #1;
    total_cnt++;
    if (bus.AddSum !== 12'h801) $display("FAIL adder_m2048: got %h expected %h", bus.AddSum, 12'h801);
    else pass_cnt++;
  endtask

  task automatic test_sigmoid();
    logic [11:0] x_v [10] = '{12'h000, 12'h040, 12'hFC0, 12'h060, 12'h0A0,
                              12'hFFF, 12'h7FF, 12'h800, 12'h098, 12'h140};
    logic [7:0]  e_v [10] = '{8'd128, 8'd192, 8'd64, 8'd208, 8'd236,
                              8'd127, 8'd255, 8'd0, 8'd235, 8'd255};
    for (int i = 0; i < 10; i++) begin
      bus.SigIn = x_v[i];
      #1;
      total_cnt++;
      if (bus.SigOut !== e_v[i])
        $display("FAIL sigmoid_%0d: in %h got %0d expected %0d", i, x_v[i], bus.SigOut, e_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_lfsr_sequence();
    logic [7:0] e_v [3] = '{8'h41, 8'h82, 8'h05};
    apply_reset(8'h20);
    release_reset();
    total_cnt++;
    if (bus.RandomData !== 8'h20) $display("FAIL lfsr_seed: got %h expected %h", bus.RandomData, 8'h20);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      total_cnt++;
      if (bus.RandomData !== e_v[i])
        $display("FAIL lfsr_step_%0d: got %h expected %h", i, bus.RandomData, e_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_seed();
    bit zero_seen = 1'b0;
    int first_ret = 0;
    apply_reset(8'h00);
    total_cnt++;
    if (bus.RandomData !== 8'h01) $display("FAIL zero_seed_load: got %h expected %h", bus.RandomData, 8'h01);
    else pass_cnt++;
    release_reset();
    for (int k = 1; k <= 300; k++) begin
      @(posedge clock); #1;
      if (bus.RandomData === 8'h00) zero_seen = 1'b1;
      if (bus.RandomData === 8'h01 && first_ret == 0) first_ret = k;
    end
    total_cnt++;
    if (zero_seen) $display("FAIL zero_seed_lockup: got zero state expected never zero");
    else pass_cnt++;
    total_cnt++;
    if (first_ret != 255) $display("FAIL zero_seed_period: got %0d expected %0d", first_ret, 255);
    else pass_cnt++;
  endtask

  task automatic test_mid_run_reset();
    apply_reset(8'h3C);
    release_reset();
    repeat (10) @(posedge clock);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.RandomData !== 8'h3C) $display("FAIL mid_reset: got %h expected %h", bus.RandomData, 8'h3C);
    else pass_cnt++;
    // Seed changes while reset is held are picked up.
    bus.SeedData = 8'h00;
    @(posedge clock); #1;
    total_cnt++;
    if (bus.RandomData !== 8'h01) $display("FAIL seed_follow_zero: got %h expected %h", bus.RandomData, 8'h01);
    else pass_cnt++;
    bus.SeedData = 8'hC3;
    @(posedge clock); #1;
    total_cnt++;
    if (bus.RandomData !== 8'hC3) $display("FAIL seed_follow: got %h expected %h", bus.RandomData, 8'hC3);
    else pass_cnt++;
    release_reset();
  endtask

  task automatic test_sample();
    bus.SigIn = 12'h000;
    apply_reset(8'h20);
    release_reset();
    @(posedge clock); #1;
    total_cnt++;
    if (bus.Sample !== 1'b1 || bus.RandomData !== 8'h41)
      $display("FAIL sample_41: got %b/%h expected 1/41", bus.Sample, bus.RandomData);
    else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++;
    if (bus.Sample !== 1'b0 || bus.RandomData !== 8'h82)
      $display("FAIL sample_82: got %b/%h expected 0/82", bus.Sample, bus.RandomData);
    else pass_cnt++;
    apply_reset(8'h80);
    total_cnt++;
    if (bus.Sample !== 1'b0 || bus.RandomData !== 8'h80)
      $display("FAIL sample_80: got %b/%h expected 0/80", bus.Sample, bus.RandomData);
    else pass_cnt++;
    // SigOut 255 beats the 8'h80 word.
    bus.SigIn = 12'h7FF;
    #1;
    total_cnt++;
    if (bus.Sample !== 1'b1) $display("FAIL sample_max: got %b expected 1", bus.Sample);
    else pass_cnt++;
    release_reset();
  endtask

  initial begin
    bus.SeedData = 8'h00;
    bus.AddA = 12'h000;
    bus.AddB = 12'h000;
    bus.SigIn = 12'h000;
    test_reset();
    test_adder();
    test_sigmoid();
    test_lfsr_sequence();
    test_zero_seed();
    test_mid_run_reset();
    test_sample();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rbm_stochastic_unit.md
# rbm_stochastic_unit

Arithmetic and stochastic-sampling primitive set for the RBM layer datapath: a 12-bit saturating signed adder (`ap_adder` function), an 8-bit piecewise-linear sigmoid (`sigmoid` function) and an 8-bit LFSR random source (`RandomGenerator` function), plus the Bernoulli sample bit `sigmoid > random`. The layer controller chains adders to form neuron pre-activations and uses the sample bit as the binary hidden/visible unit state.

## Interface
- `bitlength`, 12: adder/sigmoid input width, signed two's complement, Q5.6 (6 fractional bits).
- `sigmoid_bitlength`, 8: sigmoid output and random word width.
- `Inf`, 12'h7FF: positive saturation value; negative saturation is −Inf = 12'h801.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; loads LFSR from `SeedData`.
- `SeedData` in 8: LFSR seed, sampled while `reset` is high.
- `AddA`, `AddB` in 12: signed adder operands.
- `AddSum` out 12: saturated sum, combinational.
- `SigIn` in 12: signed Q5.6 sigmoid input.
- `SigOut` out 8: unsigned probability, value/256, combinational.
- `RandomData` out 8: current LFSR state, registered.
- `Sample` out 1: `SigOut > RandomData`, unsigned compare, combinational.

## Operation
- Adder: 13-bit exact sum of AddA+AddB; if > +2047 or result > Inf → Inf; if < −Inf (−2047) → 12'h801; else exact sum. An exact sum of −2048 saturates to 12'h801.
- Sigmoid: a = |SigIn| (|−2048| = 2048, unsigned 12-bit). Positive-side value p (units of 1/256):
  - a < 64: p = 128 + a
  - 64 ≤ a < 152: p = 160 + (a >> 1)
  - 152 ≤ a < 320: p = 216 + (a >> 3)
  - a ≥ 320: p = 256
- SigIn ≥ 0 → SigOut = min(p, 255); SigIn < 0 → SigOut = 256 − p (so 0 for a ≥ 320).
- LFSR: Fibonacci, x^8+x^6+x^5+x^4+1; fb = q[7]^q[5]^q[4]^q[3]; next = {q[6:0], fb}. Advances every clock when not in reset.
- Seed 8'h00 is replaced by 8'h01 at load (avoids lock-up); period is 255 for any nonzero state.

## Timing
- Adder, sigmoid, and Sample are purely combinational; they reflect inputs within the same cycle.
- RandomData during reset = seed (or 8'h01); all other outputs have no reset value (combinational).
- First rising edge after reset deasserts produces the first advanced state.
- Reset asserted mid-sequence immediately (asynchronously) reloads the seed; SeedData changes while reset is held are followed.

## Structure
- Shared package: Q-format constants (FRAC_BITS = 6), `Inf` / −Inf values, sigmoid breakpoints (64, 152, 320), and LFSR tap mask 8'hB8.
- Natural sub-modules: `ap_adder` (combinational, reused ×N by the layer), `sigmoid` (combinational), `RandomGenerator` (the only sequential part); this block instantiates one of each plus the comparator.

## Test plan
- Adder: 5 + (−3) → 2; 12'h7F0 + 12'h020 → 12'h7FF; 12'h800 + 12'hFFF → 12'h801; 12'h400 + 12'h3FF → 12'h7FF.
- Sigmoid: SigIn 0 → 128; 64 → 192; −64 → 64; 96 → 208; 160 → 236; −1 → 127; 12'h7FF → 255; 12'h800 → 0.
- LFSR: SeedData 8'h20, reset pulse → RandomData 8'h20; following edges → 8'h41, 8'h82, 8'h05.
- Zero seed: SeedData 0 with reset → RandomData 8'h01; the state never becomes 0 over 300 cycles; the state returns to 8'h01 after exactly 255 cycles.
- Mid-run reset: after 10 cycles, assert reset asynchronously between edges → RandomData equals the seed before the next edge.
- Sample: SigIn 0 (SigOut 128) with RandomData 8'h41 → 1; with RandomData 8'h82 → 0; with RandomData 8'h80 → 0 (strict compare).
